// File: rtl/fp16_mul_core_if.sv
// Handshake bundle between the fp16 exception stage, the normal-path multiply
// core and its downstream consumer.
interface fp16_mul_core_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        exc;
  logic [15:0] exc_q;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_q;
  logic        out_exc;

  modport master (
    output in_valid, in_a, in_b, exc, exc_q, out_ready,
    input  in_ready, out_valid, out_q, out_exc
  );

  modport slave (
    input  in_valid, in_a, in_b, exc, exc_q, out_ready,
    output in_ready, out_valid, out_q, out_exc
  );
endinterface

// File: rtl/fp16_mul_core.sv
// Sequential fp16 multiplier normal path: shift-add mantissa product, normalise,
// round-to-nearest-even; exception-stage results are forwarded untouched.
module fp16_mul_core #(
  parameter int MANT_W = 10,
  parameter int EXP_W  = 5,
  parameter int BIAS   = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  fp16_mul_core_if.slave   bus
);

  localparam int FP_W    = 1 + EXP_W + MANT_W;
  localparam int SIG_W   = MANT_W + 1;
  localparam int PROD_W  = 2 * SIG_W;
  localparam int EXPR_W  = EXP_W + 2;
  localparam int EXPF_W  = EXPR_W + 2;
  localparam int CNT_W   = $clog2(SIG_W);
  localparam int EXP_MAX = (1 << EXP_W) - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_t;

  state_t                     state_reg, state_next;
  logic                       sign_reg;
  logic [PROD_W-1:0]          mcand_reg;
  logic [SIG_W-1:0]           mplier_reg;
  logic [PROD_W-1:0]          acc_reg;
  logic [CNT_W-1:0]           cnt_reg;
  logic signed [EXPR_W-1:0]   exp_reg;
  logic [FP_W-1:0]            q_reg;
  logic                       exc_out_reg;

  logic                       accept;
  logic                       norm_done;

  // Operand decode: subnormals get no hidden bit and an effective exponent of 1
  logic [EXP_W-1:0]           ea_raw, eb_raw, ea_eff, eb_eff;
  logic [SIG_W-1:0]           sig_a, sig_b;
  logic [EXPR_W-1:0]          exp_init;

  assign ea_raw   = bus.in_a[MANT_W +: EXP_W];
  assign eb_raw   = bus.in_b[MANT_W +: EXP_W];
  assign ea_eff   = (ea_raw == '0) ? EXP_W'(1) : ea_raw;
  assign eb_eff   = (eb_raw == '0) ? EXP_W'(1) : eb_raw;
  assign sig_a    = {(ea_raw != '0), bus.in_a[MANT_W-1:0]};
  assign sig_b    = {(eb_raw != '0), bus.in_b[MANT_W-1:0]};
  assign exp_init = EXPR_W'(ea_eff) + EXPR_W'(eb_eff) - EXPR_W'(BIAS);

  assign accept    = bus.in_valid && (state_reg == S_IDLE);
  assign norm_done = (acc_reg == '0) || acc_reg[PROD_W-1] || acc_reg[PROD_W-2];

  // Rounding datapath, evaluated while in ROUND
  logic [MANT_W-1:0]          mant_raw;
  logic                       guard_bit, sticky_bit, rnd_inc;
  logic [MANT_W:0]            mant_sum;
  logic [EXPF_W-1:0]          exp_base, exp_fin;
  logic [FP_W-1:0]            round_q;

  always_comb begin
    if (acc_reg[PROD_W-1]) begin
      mant_raw   = acc_reg[PROD_W-2 -: MANT_W];
      guard_bit  = acc_reg[PROD_W-2-MANT_W];
      sticky_bit = |acc_reg[PROD_W-3-MANT_W:0];
    end else begin
      mant_raw   = acc_reg[PROD_W-3 -: MANT_W];
      guard_bit  = acc_reg[PROD_W-3-MANT_W];
      sticky_bit = |acc_reg[PROD_W-4-MANT_W:0];
    end
    rnd_inc  = guard_bit && (sticky_bit || mant_raw[0]);
    mant_sum = {1'b0, mant_raw} + (MANT_W+1)'(rnd_inc);
    exp_base = {{(EXPF_W-EXPR_W){exp_reg[EXPR_W-1]}}, exp_reg};
    exp_fin  = exp_base + EXPF_W'(acc_reg[PROD_W-1]) + EXPF_W'(mant_sum[MANT_W]);

    if (acc_reg == '0) begin
      round_q = {sign_reg, {(EXP_W+MANT_W){1'b0}}};
    end else if (!exp_fin[EXPF_W-1] && (exp_fin >= EXPF_W'(EXP_MAX))) begin
      round_q = {sign_reg, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
    end else if (exp_fin[EXPF_W-1] || (exp_fin == '0)) begin
      round_q = {sign_reg, {(EXP_W+MANT_W){1'b0}}};
    end else begin
      // A rounding carry leaves the low mantissa bits at zero already
      round_q = {sign_reg, exp_fin[EXP_W-1:0], mant_sum[MANT_W-1:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (accept) state_next = bus.exc ? S_DONE : S_MUL;
      S_MUL:   if (cnt_reg == CNT_W'(SIG_W-1)) state_next = S_NORM;
      S_NORM:  if (norm_done) state_next = S_ROUND;
      S_ROUND: state_next = S_DONE;
      S_DONE:  if (bus.out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_reg == S_IDLE);
    bus.out_valid = (state_reg == S_DONE);
    bus.out_q     = q_reg;
    bus.out_exc   = exc_out_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_reg    <= 1'b0;
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      acc_reg     <= '0;
      cnt_reg     <= '0;
      exp_reg     <= '0;
      q_reg       <= '0;
      exc_out_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            if (bus.exc) begin
              q_reg       <= bus.exc_q;
              exc_out_reg <= 1'b1;
            end else begin
              sign_reg   <= bus.in_a[FP_W-1] ^ bus.in_b[FP_W-1];
              mcand_reg  <= {{(PROD_W-SIG_W){1'b0}}, sig_a};
              mplier_reg <= sig_b;
              acc_reg    <= '0;
              cnt_reg    <= '0;
              exp_reg    <= $signed(exp_init);
            end
          end
        end
        S_MUL: begin
          if (mplier_reg[0]) acc_reg <= acc_reg + mcand_reg;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          cnt_reg    <= cnt_reg + CNT_W'(1);
        end
        S_NORM: begin
          // Products of subnormal operands are walked up to bit 20 one bit per cycle
          if (!norm_done) begin
            acc_reg <= acc_reg << 1;
            exp_reg <= exp_reg - EXPR_W'(1);
          end
        end
        S_ROUND: begin
          q_reg       <= round_q;
          exc_out_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
